wb_slave_decode: RTL and testbench

- Single-master Wishbone classic address decoder and response collector.
- Sits directly upstream of the software-register slaves such as the write-only control registers. It fans one bus master out to NUM_SLAVES slave ports.
- Registers every transaction so that each slave sees exactly one strobe window per master access, then returns exactly one ack or err pulse to the master.
- Generates bus errors for unmapped addresses and for slaves that fail to respond within a timeout.

---
 rtl/wb_slave_decode_if.sv | 43 ++++
 rtl/wb_slave_decode.sv | 164 ++++++++++++++++
 tb/tb_wb_slave_decode.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_decode_if.sv
// Bus bundle between one Wishbone master, the address decoder and its slave ports.
// Latency: none; this is wiring only.
// Backpressure: classic Wishbone; a transfer is held until ack/err, no credits.
interface wb_slave_decode_if #(
    parameter int NUM_SLAVES = 4
);
    // master side
    logic                     wbm_cyc_i;
    logic                     wbm_stb_i;
    logic                     wbm_we_i;
    logic [3:0]               wbm_sel_i;
    logic [31:0]              wbm_adr_i;
    logic [31:0]              wbm_dat_i;
    logic [31:0]              wbm_dat_o;
    logic                     wbm_ack_o;
    logic                     wbm_err_o;
    // slave side
    logic [NUM_SLAVES-1:0]    wbs_cyc_o;
    logic [NUM_SLAVES-1:0]    wbs_stb_o;
    logic                     wbs_we_o;
    logic [3:0]               wbs_sel_o;
    logic [31:0]              wbs_adr_o;
    logic [31:0]              wbs_dat_o;
    logic [32*NUM_SLAVES-1:0] wbs_dat_i;
    logic [NUM_SLAVES-1:0]    wbs_ack_i;
    logic [NUM_SLAVES-1:0]    wbs_err_i;

    // Decoder view: answers the master, drives the slave ports.
    modport slave (
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );

    // Environment view: drives the master request and the slave responses.
    modport master (
        output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        output wbs_dat_i, wbs_ack_i, wbs_err_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_slave_decode.sv
// Wishbone classic decoder: one master fanned out to NUM_SLAVES slaves, one registered response per access.
// Latency: slave strobe high after the master sample edge; master ack/err high after the slave response edge.
// Backpressure: master is held until ack/err; unmapped or silent slaves are answered with err.
module wb_slave_decode #(
    parameter int                      NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h30, 32'h20, 32'h10, 32'h00},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_HIGH = {32'h3F, 32'h2F, 32'h1F, 32'h0F},
    parameter int                      TIMEOUT    = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_slave_decode_if.slave     bus,
    output logic [15:0]          err_count
);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q;
    logic [TW-1:0]         tmo_q;
    logic                  resp_err_q;

    logic                  hit;
    logic [IW-1:0]         hit_idx;
    logic [NUM_SLAVES-1:0] slv_sel;
    logic                  sel_ack;
    logic                  sel_err;
    logic [31:0]           rd_slice;
    logic                  launch;
    logic                  go_resp;
    logic                  go_err;

    // Address decode; scanning from the top index down lets the lowest overlapping slave win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (bus.wbm_adr_i >= SLAVE_BASE[32*i +: 32] && bus.wbm_adr_i <= SLAVE_HIGH[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // One-hot slave select while BUSY, plus the selected slave's response and read data.
    always_comb begin
        slv_sel  = '0;
        rd_slice = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_sel[i] = (state_q == BUSY) && (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                rd_slice = bus.wbs_dat_i[32*i +: 32];
            end
        end
        sel_ack = |(bus.wbs_ack_i & slv_sel);
        sel_err = |(bus.wbs_err_i & slv_sel);
    end

    // Next-state logic: launch, response/timeout/abort decisions.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        go_resp = 1'b0;
        go_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    launch = 1'b1;
                    if (hit) begin
                        state_d = BUSY;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                        go_err  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!bus.wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_err) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end else if (sel_ack) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end
            end
            RESP: begin
                state_d = HOLD;
            end
            HOLD: begin
                // A strobe held across the response must fall before the next access.
                if (!bus.wbm_stb_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, timeout counter, response capture and error counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q          <= '0;
            tmo_q          <= '0;
            resp_err_q     <= 1'b0;
            bus.wbs_we_o   <= 1'b0;
            bus.wbs_sel_o  <= '0;
            bus.wbs_adr_o  <= '0;
            bus.wbs_dat_o  <= '0;
            bus.wbm_dat_o  <= '0;
            err_count      <= '0;
        end else begin
            if (launch) begin
                idx_q         <= hit_idx;
                tmo_q         <= '0;
                bus.wbs_we_o  <= bus.wbm_we_i;
                bus.wbs_sel_o <= bus.wbm_sel_i;
                bus.wbs_adr_o <= bus.wbm_adr_i;
                bus.wbs_dat_o <= bus.wbm_dat_i;
            end else if (state_q == BUSY && state_d == BUSY) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (go_resp) begin
                resp_err_q    <= go_err;
                // Read data only on a successful read; writes and errors return zero.
                bus.wbm_dat_o <= (!go_err && !bus.wbs_we_o) ? rd_slice : 32'h0;
                if (go_err && err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

    assign bus.wbs_cyc_o = slv_sel;
    assign bus.wbs_stb_o = slv_sel;
    assign bus.wbm_ack_o = (state_q == RESP) && !resp_err_q;
    assign bus.wbm_err_o = (state_q == RESP) && resp_err_q;

endmodule

// File: tb/tb_wb_slave_decode.sv
// Randomized bench for wb_slave_decode against a transaction-level reference model.
// Latency: each access is predicted as a whole (strobe window, response cycle, data, error count).
// Backpressure: bench slaves respond after a chosen delay, or never, to exercise the timeout.
module tb_wb_slave_decode;
    localparam int NS  = 4;
    localparam int TMO = 8;
    localparam logic [32*NS-1:0] BASE = {32'h30, 32'h20, 32'h10, 32'h00};
    localparam logic [32*NS-1:0] HIGH = {32'h3F, 32'h2F, 32'h1F, 32'h0F};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_count;

    wb_slave_decode_if #(.NUM_SLAVES(NS)) bus ();

    wb_slave_decode #(
        .NUM_SLAVES (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_HIGH (HIGH),
        .TIMEOUT    (TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: address map, last returned data, error responses issued.
    int unsigned m_base [NS] = '{32'h00, 32'h10, 32'h20, 32'h30};
    int unsigned m_high [NS] = '{32'h0F, 32'h1F, 32'h2F, 32'h3F};
    logic [31:0] m_dat  = 32'h0;
    int          m_errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= m_base[i] && a <= m_high[i]) return i;
        end
        return -1;
    endfunction

    // mode: 0 ack, 1 err, 2 ack+err together, 3 never respond.
    // lat: cycles the slave waits after first seeing its strobe before responding.
    // abort_at >= 0: master drops cyc that many cycles into the strobe window.
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input int mode, input int lat,
                          input logic [31:0] rdata, input int hold_extra, input int abort_at);
        int          h;
        int          ab;
        int          rc;
        int          c_end;
        bit          resp;
        bit          exp_err;
        logic [3:0]  exp_stb;
        logic [3:0]  ack_v;
        logic [3:0]  err_v;
        logic [127:0] dv;
        h       = decode(adr);
        ab      = (h < 0) ? -1 : abort_at;
        resp    = 1'b1;
        exp_err = 1'b0;
        if (h < 0) begin
            rc = 1; exp_err = 1'b1;
        end else if (ab >= 0) begin
            rc = 2 + ab; resp = 1'b0;
        end else if (mode == 3 || 2 + lat > 1 + TMO) begin
            rc = 1 + TMO; exp_err = 1'b1;
        end else begin
            rc = 2 + lat; exp_err = (mode != 0);
        end
        c_end = resp ? rc + hold_extra + 2 : rc;

        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        bus.wbm_we_i  = we;
        bus.wbm_sel_i = sel;
        bus.wbm_adr_i = adr;
        bus.wbm_dat_i = wdat;
        for (int c = 1; c <= c_end; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_stb = (h >= 0 && c < rc) ? (4'b0001 << h) : 4'b0000;
            if (resp && c == rc) begin
                m_dat = (!exp_err && !we) ? rdata : 32'h0;
                if (exp_err && m_errs < 65535) m_errs++;
            end
            chk("slave_stb", {28'h0, bus.wbs_stb_o}, {28'h0, exp_stb});
            chk("slave_cyc", {28'h0, bus.wbs_cyc_o}, {28'h0, exp_stb});
            chk("master_ack", {31'h0, bus.wbm_ack_o}, {31'h0, resp && c == rc && !exp_err});
            chk("master_err", {31'h0, bus.wbm_err_o}, {31'h0, resp && c == rc && exp_err});
            chk("master_dat", bus.wbm_dat_o, m_dat);
            chk("err_count", {16'h0, err_count}, m_errs[31:0]);
            if (c == 1) begin
                chk("shared_adr", bus.wbs_adr_o, adr);
                chk("shared_dat", bus.wbs_dat_o, wdat);
                chk("shared_we", {31'h0, bus.wbs_we_o}, {31'h0, we});
                chk("shared_sel", {28'h0, bus.wbs_sel_o}, {28'h0, sel});
            end
            // Non-selected slaves chatter randomly; only the addressed slave's response counts.
            ack_v = 4'($urandom);
            err_v = 4'($urandom);
            dv    = {$urandom, $urandom, $urandom, $urandom};
            if (h >= 0) begin
                ack_v[h] = 1'b0;
                err_v[h] = 1'b0;
                if (ab < 0 && mode != 3 && c == 1 + lat) begin
                    ack_v[h] = (mode == 0 || mode == 2);
                    err_v[h] = (mode == 1 || mode == 2);
                    dv[32*h +: 32] = rdata;
                end
            end
            bus.wbs_ack_i = ack_v;
            bus.wbs_err_i = err_v;
            bus.wbs_dat_i = dv;
            if (ab >= 0 && c == 1 + ab) begin
                bus.wbm_cyc_i = 1'b0;
                bus.wbm_stb_i = 1'b0;
            end
            if (resp && c == rc + hold_extra) begin
                bus.wbm_cyc_i = 1'b0;
                bus.wbm_stb_i = 1'b0;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        bus.wbm_we_i  = 1'b0;
        bus.wbm_sel_i = 4'h0;
        bus.wbm_adr_i = 32'h0;
        bus.wbm_dat_i = 32'h0;
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = '0;
        bus.wbs_err_i = '0;
        #12;
        chk("rst_stb", {28'h0, bus.wbs_stb_o}, 32'h0);
        chk("rst_ack", {31'h0, bus.wbm_ack_o}, 32'h0);
        chk("rst_err", {31'h0, bus.wbm_err_o}, 32'h0);
        chk("rst_dat", bus.wbm_dat_o, 32'h0);
        chk("rst_cnt", {16'h0, err_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed accesses.
        do_txn(32'h14, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0, 0, -1);       // write, slave 1
        do_txn(32'h28, 1'b0, 32'h0, 4'hF, 0, 1, 32'h12345678, 4, -1);        // read, stb held 4 more
        do_txn(32'h100, 1'b0, 32'h0, 4'hF, 0, 1, 32'h0, 0, -1);              // unmapped
        do_txn(32'h00, 1'b0, 32'h0, 4'h3, 3, 0, 32'h0, 0, -1);               // silent slave, timeout
        do_txn(32'h30, 1'b0, 32'h0, 4'hF, 2, 1, 32'hCAFEF00D, 0, -1);        // ack+err together
        do_txn(32'h3F, 1'b0, 32'h0, 4'hF, 0, 7, 32'hA5A5A5A5, 1, -1);        // ack on timeout edge
        do_txn(32'h1C, 1'b1, 32'h55, 4'h1, 3, 0, 32'h0, 0, 2);               // abort in BUSY
        do_txn(32'h0F, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0BADC0DE, 2, -1);        // zero-wait slave

        // Randomized accesses.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            int          ab;
            int          md;
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 32'h3F));
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(32'h40, 32'hFFF));
            else a = $urandom;
            md = $urandom_range(0, 5);
            if (md > 3) md = 0;
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 2) : -1;
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), (ab >= 0) ? 3 : md,
                   $urandom_range(0, 9), $urandom, $urandom_range(0, 3), ab);
        end

        // Asynchronous reset in the middle of an access.
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        bus.wbm_we_i  = 1'b0;
        bus.wbm_adr_i = 32'h04;
        bus.wbs_ack_i = '0;
        bus.wbs_err_i = '0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_stb", {28'h0, bus.wbs_stb_o}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        m_errs = 0;
        m_dat  = 32'h0;
        chk("arst_stb", {28'h0, bus.wbs_stb_o}, 32'h0);
        chk("arst_cyc", {28'h0, bus.wbs_cyc_o}, 32'h0);
        chk("arst_ack", {31'h0, bus.wbm_ack_o}, 32'h0);
        chk("arst_err", {31'h0, bus.wbm_err_o}, 32'h0);
        chk("arst_dat", bus.wbm_dat_o, m_dat);
        chk("arst_adr", bus.wbs_adr_o, 32'h0);
        chk("arst_cnt", {16'h0, err_count}, m_errs[31:0]);
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_txn(32'h200, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 0, -1);
        do_txn(32'h24, 1'b0, 32'h0, 4'hF, 0, 2, 32'h87654321, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
